// File: rtl/state_dump_engine.sv
// Snapshot streamer: on a trigger, scans the register file and then the data memory
// through their spare async read ports and emits each word over a valid/ready port.
module state_dump_engine #(
  parameter int DATA_W    = 32,
  parameter int REG_DEPTH = 32,
  parameter int MEM_DEPTH = 32,
  parameter int IDX_W     = 5,
  parameter int CNT_W     = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [1:0]        trig_mode_i,
  input  logic [CNT_W-1:0]  trig_cycle_i,
  input  logic              start_i,
  output logic [IDX_W-1:0]  rf_addr_o,
  input  logic [DATA_W-1:0] rf_data_i,
  output logic [IDX_W-1:0]  mem_addr_o,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic [DATA_W-1:0] dump_data_o,
  output logic              dump_src_o,
  output logic [IDX_W-1:0]  dump_idx_o,
  output logic              dump_last_o,
  output logic [CNT_W-1:0]  dump_cycle_o,
  output logic              busy_o,
  output logic              overrun_o
);

  typedef enum logic [1:0] {IDLE, SCAN_RF, SCAN_MEM} state_t;

  localparam logic [1:0]       MODE_ONESHOT  = 2'b01;
  localparam logic [1:0]       MODE_PERIODIC = 2'b10;
  localparam logic [1:0]       MODE_MANUAL   = 2'b11;
  localparam logic [IDX_W-1:0] RF_LAST       = IDX_W'(REG_DEPTH - 1);
  localparam logic [IDX_W-1:0] MEM_LAST      = IDX_W'(MEM_DEPTH - 1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cyc, pcnt;
  logic [IDX_W-1:0]   idx;
  logic               armed, busy, overrun;
  logic               per_hit, cond, fire, load, idx_end, accept_last;

  logic [DATA_W-1:0]  data_p1;
  logic               src_p1, last_p1, vld_p1;
  logic [IDX_W-1:0]   idx_p1;
  logic [CNT_W-1:0]   cycle_p1;

  // An interval of 0 would make trig_cycle_i-1 wrap to all ones, so it is masked.
  assign per_hit = (trig_cycle_i != '0) && (pcnt == trig_cycle_i - CNT_W'(1));

  always_comb begin
    cond = 1'b0;
    case (trig_mode_i)
      MODE_ONESHOT:  cond = armed && (cyc == trig_cycle_i);
      MODE_PERIODIC: cond = per_hit;
      MODE_MANUAL:   cond = start_i;
      default:       cond = 1'b0;
    endcase
  end

  assign fire        = cond && !busy;
  assign load        = (state != IDLE) && (!vld_p1 || dump_ready_i);
  assign idx_end     = (state == SCAN_RF  && idx == RF_LAST) ||
                       (state == SCAN_MEM && idx == MEM_LAST);
  assign accept_last = vld_p1 && dump_ready_i && last_p1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (fire)            state_nxt = SCAN_RF;
      SCAN_RF:  if (load && idx_end) state_nxt = SCAN_MEM;
      SCAN_MEM: if (load && idx_end) state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  // Trigger bookkeeping; a periodic hit restarts the interval even when it is missed.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cyc     <= '0;
      pcnt    <= '0;
      armed   <= 1'b1;
      busy    <= 1'b0;
      overrun <= 1'b0;
      idx     <= '0;
    end else begin
      cyc <= cyc + CNT_W'(1);
      if (fire || (trig_mode_i == MODE_PERIODIC && per_hit)) pcnt <= '0;
      else                                                   pcnt <= pcnt + CNT_W'(1);
      if (fire && trig_mode_i == MODE_ONESHOT) armed <= 1'b0;
      if (fire)             busy <= 1'b1;
      else if (accept_last) busy <= 1'b0;
      if (cond && busy) overrun <= 1'b1;
      if (fire)         idx <= '0;
      else if (load)    idx <= idx_end ? '0 : idx + IDX_W'(1);
    end
  end

  // Output stage p1: a word loads only when the slot is empty or being drained.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p1   <= 1'b0;
      data_p1  <= '0;
      src_p1   <= 1'b0;
      idx_p1   <= '0;
      last_p1  <= 1'b0;
      cycle_p1 <= '0;
    end else begin
      if (fire) cycle_p1 <= cyc;
      if (load) begin
        vld_p1  <= 1'b1;
        data_p1 <= (state == SCAN_RF) ? rf_data_i : mem_data_i;
        src_p1  <= (state == SCAN_MEM);
        idx_p1  <= idx;
        last_p1 <= (state == SCAN_MEM) && (idx == MEM_LAST);
      end else if (vld_p1 && dump_ready_i) begin
        vld_p1  <= 1'b0;
        last_p1 <= 1'b0;
      end
    end
  end

  assign rf_addr_o    = (state == SCAN_RF)  ? idx : '0;
  assign mem_addr_o   = (state == SCAN_MEM) ? idx : '0;
  assign dump_valid_o = vld_p1;
  assign dump_data_o  = data_p1;
  assign dump_src_o   = src_p1;
  assign dump_idx_o   = idx_p1;
  assign dump_last_o  = last_p1;
  assign dump_cycle_o = cycle_p1;
  assign busy_o       = busy;
  assign overrun_o    = overrun;

endmodule

// File: tb/tb_state_dump_engine.sv
// Scoreboard bench for state_dump_engine: expected beats are queued at trigger time and
// a negedge monitor pops and compares each accepted beat.
module tb_state_dump_engine;

  typedef struct packed {
    logic [31:0] data;
    logic        src;
    logic [4:0]  idx;
    logic        last;
    logic [15:0] cycle;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  mode = 2'b00;
  logic [15:0] trig = '0;
  logic        start = 1'b0;
  logic [4:0]  rf_addr, mem_addr;
  logic [31:0] rf_data, mem_data;
  logic        dump_valid, dump_src, dump_last, busy, overrun;
  logic        dump_ready = 1'b1;
  logic        toggle_en = 1'b0;
  logic [31:0] dump_data;
  logic [4:0]  dump_idx;
  logic [15:0] dump_cycle;
  logic [15:0] tb_cyc;

  logic [31:0] rf  [32];
  logic [31:0] mem [32];
  beat_t       q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          nbeats   = 0;

  state_dump_engine dut (
    .clk_i(clk), .rst_i(rst), .trig_mode_i(mode), .trig_cycle_i(trig), .start_i(start),
    .rf_addr_o(rf_addr), .rf_data_i(rf_data), .mem_addr_o(mem_addr), .mem_data_i(mem_data),
    .dump_valid_o(dump_valid), .dump_ready_i(dump_ready), .dump_data_o(dump_data),
    .dump_src_o(dump_src), .dump_idx_o(dump_idx), .dump_last_o(dump_last),
    .dump_cycle_o(dump_cycle), .busy_o(busy), .overrun_o(overrun)
  );

  always #5 clk = ~clk;

  assign rf_data  = rf[rf_addr];
  assign mem_data = mem[mem_addr];

  always @(posedge clk or posedge rst) begin
    if (rst) tb_cyc <= '0;
    else     tb_cyc <= tb_cyc + 16'd1;
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      dump_ready = toggle_en ? ~dump_ready : 1'b1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_snapshot(input logic [15:0] stamp);
    beat_t b;
    for (int i = 0; i < 32; i++) begin
      b.data = 32'(3 * i); b.src = 1'b0; b.idx = 5'(i); b.last = 1'b0; b.cycle = stamp;
      q.push_back(b);
    end
    for (int i = 0; i < 32; i++) begin
      b.data = 32'(100 + i); b.src = 1'b1; b.idx = 5'(i); b.last = (i == 31); b.cycle = stamp;
      q.push_back(b);
    end
  endtask

  task automatic do_reset(input logic [1:0] m, input logic [15:0] t);
    @(posedge clk); #1;
    rst = 1'b1; mode = m; trig = t; start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    push_snapshot(tb_cyc);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int bound);
    for (int k = 0; k < bound && busy; k++) @(negedge clk);
    check(name, 64'(busy), 64'd0);
  endtask

  // Monitor: compares every accepted beat and checks stability while stalled.
  initial begin
    beat_t cur, prev, exp;
    logic  hold;
    hold = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      cur = '{dump_data, dump_src, dump_idx, dump_last, dump_cycle};
      if (hold && !rst) check("hold_stable", 64'({dump_valid, cur}), 64'({1'b1, prev}));
      if (dump_valid && dump_ready) begin
        nbeats++;
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got %0h expected no beat", 64'(cur));
        end else begin
          exp = q.pop_front();
          check("beat", 64'(cur), 64'(exp));
        end
      end
      hold = dump_valid && !dump_ready;
      prev = cur;
    end
  end

  initial begin
    int busy_cyc, nb0;
    for (int i = 0; i < 32; i++) begin
      rf[i]  = 32'(3 * i);
      mem[i] = 32'(100 + i);
    end

    // Reset state
    #12;
    check("rst_valid", 64'(dump_valid), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_overrun", 64'(overrun), 0);
    check("rst_last", 64'(dump_last), 0);
    check("rst_data", 64'(dump_data), 0);
    check("rst_cycle", 64'(dump_cycle), 0);
    check("rst_rf_addr", 64'(rf_addr), 0);
    check("rst_mem_addr", 64'(mem_addr), 0);

    // Manual trigger, ready held high
    do_reset(2'b11, 16'd0);
    repeat (3) @(posedge clk);
    pulse_start();
    @(negedge clk);
    check("t1_busy_rise", 64'(busy), 1);
    check("t1_no_valid_at_trigger", 64'(dump_valid), 0);
    busy_cyc = 1;
    for (int k = 0; k < 300 && busy; k++) begin
      @(negedge clk);
      if (k == 0) check("t1_first_valid", 64'(dump_valid), 1);
      if (busy) busy_cyc++;
    end
    check("t1_busy_len", 64'(busy_cyc), 65);
    check("t1_q_empty", 64'(q.size()), 0);

    // Manual trigger, ready toggling
    toggle_en = 1'b1;
    pulse_start();
    @(negedge clk);
    wait_idle("t2_idle", 400);
    check("t2_q_empty", 64'(q.size()), 0);
    toggle_en = 1'b0;
    repeat (2) @(posedge clk);

    // Reset mid-scan at idx 10 of the register file
    do_reset(2'b11, 16'd0);
    pulse_start();
    for (int k = 0; k < 50 && !(dump_valid && !dump_src && dump_idx == 5'd10); k++) @(negedge clk);
    check("t5_reached_idx10", 64'({dump_valid, dump_src, dump_idx}), 64'({1'b1, 1'b0, 5'd10}));
    #2 rst = 1'b1;
    #1;
    check("t5_valid_cleared", 64'(dump_valid), 0);
    check("t5_busy_cleared", 64'(busy), 0);
    check("t5_outputs_cleared", 64'({dump_data, dump_idx, dump_cycle, dump_last}), 0);
    q.delete();
    @(posedge clk); #1 rst = 1'b0;
    nb0 = nbeats;
    repeat (100) @(posedge clk);
    check("t5_no_beats_after_release", 64'(nbeats - nb0), 0);
    pulse_start();
    @(negedge clk);
    wait_idle("t5_restart_idle", 300);
    check("t5_restart_q_empty", 64'(q.size()), 0);

    // One-shot at cycle 1200, must not refire after the counter wraps
    do_reset(2'b01, 16'd1200);
    nb0 = nbeats;
    push_snapshot(16'd1200);
    repeat (1300) @(posedge clk);
    @(negedge clk);
    wait_idle("t3_idle", 300);
    check("t3_q_empty", 64'(q.size()), 0);
    repeat (65536) @(posedge clk);
    check("t3_beats", 64'(nbeats - nb0), 64);
    check("t3_overrun", 64'(overrun), 0);

    // Periodic, interval 100: no overrun
    do_reset(2'b10, 16'd100);
    push_snapshot(16'd99);
    push_snapshot(16'd199);
    push_snapshot(16'd299);
    repeat (320) @(posedge clk);
    #1 mode = 2'b00;
    @(negedge clk);
    wait_idle("t4a_idle", 300);
    check("t4a_q_empty", 64'(q.size()), 0);
    check("t4a_overrun", 64'(overrun), 0);

    // Periodic, interval 50: missed triggers set overrun and restart the interval
    do_reset(2'b10, 16'd50);
    push_snapshot(16'd49);
    push_snapshot(16'd149);
    push_snapshot(16'd249);
    repeat (270) @(posedge clk);
    #1 mode = 2'b00;
    @(negedge clk);
    wait_idle("t4b_idle", 300);
    check("t4b_q_empty", 64'(q.size()), 0);
    check("t4b_overrun", 64'(overrun), 1);

    // Periodic with interval 0 never fires
    do_reset(2'b10, 16'd0);
    nb0 = nbeats;
    repeat (1000) @(posedge clk);
    @(negedge clk);
    check("t6_beats", 64'(nbeats - nb0), 0);
    check("t6_busy", 64'(busy), 0);
    check("t6_overrun", 64'(overrun), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
